// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply into a 2*XLEN accumulator and restoring divide, UNROLL
// bits per RUN cycle. Operands are reduced to magnitudes on accept and the
// sign is re-applied when the result register loads.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; result holds the last completed value
// S_RUN  | iterating; count==0 means the accumulator is final
// S_DONE | one-cycle done pulse, result valid
module rv_muldiv_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              load_op, step_en, load_res;

  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   mag;       // multiplicand or divisor magnitude
  logic [2:0]        op;
  logic              neg;
  logic              special;   // acc[XLEN-1:0] already holds the final result

  // operand decode on the accepting edge
  logic              is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b, special_val;
  logic              div_zero, div_ovf, special_in, neg_in;

  // iteration and result formatting
  logic [2*XLEN-1:0] acc_step, t, prod_fin;
  logic [XLEN:0]     sum, rs, diff;
  logic [XLEN-1:0]   mul_sel, quot_fin, rem_fin, fin;

  // signedness, magnitudes and special-case detection from the raw inputs
  always_comb begin
    is_div      = funct3[2];
    a_signed    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed    = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa          = a_signed & a[XLEN-1];
    sb          = b_signed & b[XLEN-1];
    abs_a       = sa ? -a : a;
    abs_b       = sb ? -b : b;
    div_zero    = is_div && (b == '0);
    div_ovf     = is_div && !funct3[0] && (a == MIN_NEG) && (b == '1);
    special_in  = div_zero | div_ovf;
    special_val = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
    neg_in      = (is_div && funct3[1]) ? sa : (sa ^ sb);
  end

  // UNROLL iterations of shift-add or restoring-divide on the accumulator
  always_comb begin
    t    = acc;
    sum  = '0;
    rs   = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op[2]) begin
        sum = {1'b0, t[2*XLEN-1:XLEN]} + (t[0] ? {1'b0, mag} : '0);
        t   = {sum, t[XLEN-1:1]};
      end else begin
        rs   = {t[2*XLEN-1:XLEN], t[XLEN-1]};
        diff = rs - {1'b0, mag};
        if (!diff[XLEN])
          t = {diff[XLEN-1:0], t[XLEN-2:0], 1'b1};
        else
          t = {rs[XLEN-1:0], t[XLEN-2:0], 1'b0};
      end
    end
    acc_step = t;
  end

  // sign correction and result select
  always_comb begin
    prod_fin = neg ? -acc : acc;
    mul_sel  = (op[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    quot_fin = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fin  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special)
      fin = acc[XLEN-1:0];
    else if (!op[2])
      fin = mul_sel;
    else
      fin = op[1] ? rem_fin : quot_fin;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state and control strobes; special cases take one RUN pass with
  // count already 0, giving them a fixed one-edge turnaround
  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    step_en   = 1'b0;
    load_res  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !kill) begin
          load_op   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (count == '0) begin
          load_res  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          step_en = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      mag     <= '0;
      op      <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      result  <= '0;
    end else begin
      if (load_op) begin
        op      <= funct3;
        neg     <= neg_in;
        special <= special_in;
        mag     <= is_div ? abs_b : abs_a;
        count   <= special_in ? '0 : CW'(N);
        if (special_in)
          acc <= {{XLEN{1'b0}}, special_val};
        else
          acc <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
      end
      if (step_en) begin
        acc   <= acc_step;
        count <= count - CW'(1);
      end
      if (load_res)
        result <= fin;
    end
  end

endmodule
